// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter (reverse double-dabble,
// one shift per clock) with a start/ready/valid handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    conversion request, sampled only while ready=1
//   bcd_in   packed BCD, digit 0 (units) in [3:0]
//   ready    converter idle, start will be accepted
//   valid    one-cycle pulse marking a new bin_out/err
//   bin_out  converted value, held until the next result
//   err      last request contained a digit > 9
//
// Build option: define BCD_CHK_EN to add the digit range check. Without it,
// err is held at 0 and every accepted request is shifted.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned OUT    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  valid,
    output logic [OUT-1:0]        bin_out,
    output logic                  err
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned SW = BW + OUT;
    localparam int unsigned CW = $clog2(OUT + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]    state, state_nxt;
    logic [SW-1:0] sreg, sreg_nxt;
    logic [SW-1:0] shifted;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ready_nxt;
    logic          valid_nxt;
    logic          err_nxt;
    logic [OUT-1:0] bin_nxt;

    // One iteration: shift right, then correct every digit that reached >= 8.
    always_comb begin
        shifted = sreg >> 1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (shifted[OUT + 4*i + 3]) begin
                shifted[OUT + 4*i +: 4] = shifted[OUT + 4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_CHK_EN
    logic bad_digit;

    // Any nibble in 10..15 (MSB set together with bit 2 or bit 1).
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i + 3] && (bcd_in[4*i + 2] || bcd_in[4*i + 1])) begin
                bad_digit = 1'b1;
            end
        end
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        ready_nxt = ready;
        valid_nxt = 1'b0;
        err_nxt   = err;
        bin_nxt   = bin_out;

        case (state)
            IDLE: begin
                if (start) begin
`ifdef BCD_CHK_EN
                    if (bad_digit) begin
                        valid_nxt = 1'b1;
                        err_nxt   = 1'b1;
                        bin_nxt   = '0;
                    end else
`endif
                    begin
                        sreg_nxt  = {bcd_in, {OUT{1'b0}}};
                        cnt_nxt   = '0;
                        ready_nxt = 1'b0;
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sreg_nxt = shifted;
                cnt_nxt  = cnt + CW'(1);
                // Result is taken from the post-shift value of the final iteration.
                if (cnt_nxt == CW'(OUT)) begin
                    bin_nxt   = shifted[OUT-1:0];
                    valid_nxt = 1'b1;
                    err_nxt   = 1'b0;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            ready   <= 1'b1;
            valid   <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            cnt     <= cnt_nxt;
            ready   <= ready_nxt;
            valid   <= valid_nxt;
            err     <= err_nxt;
            bin_out <= bin_nxt;
        end
    end

endmodule
